// File: rtl/bitwise_serial_unit.sv
// bitwise_serial_unit
//   Bit-serial front end for the bitwise logic path. Operand A then operand B
//   arrive LSB first over an in_valid/in_ready handshake; the opcode is taken
//   with the first A bit. After one EXEC cycle the WIDTH-bit result is
//   returned LSB first over an out_valid/out_ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_bit/in_op valid this cycle
//   in_ready   block accepts an input bit this cycle (state decode only)
//   in_bit     serial operand bit
//   in_op      opcode: 00 OR, 01 AND, 10 XOR, 11 NOR
//   out_valid  out_bit valid
//   out_ready  sink accepts out_bit
//   out_bit    serial result bit
//   out_last   marks result bit WIDTH-1
//   busy       high unless idle in LOAD_A with no bits received
//
// state  | meaning
// LOAD_A | shifting in operand A (opcode latched on first bit)
// LOAD_B | shifting in operand B
// EXEC   | one cycle, result computed from A, B and latched opcode
// SEND   | shifting out result, waits on out_ready

module bitwise_serial_unit #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic [1:0] in_op,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_bit,
  output logic       out_last,
  output logic       busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    EXEC   = 2'd2,
    SEND   = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] op_result;
  logic [1:0]       op_reg;
  logic             in_xfer;
  logic             out_xfer;
  logic             cnt_last;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign cnt_last = (cnt == CNT_MAX);
  assign busy     = !((state == LOAD_A) && (cnt == '0));

  always_comb begin
    op_result = '0;
    case (op_reg)
      2'b00:   op_result = a_reg | b_reg;
      2'b01:   op_result = a_reg & b_reg;
      2'b10:   op_result = a_reg ^ b_reg;
      default: op_result = ~(a_reg | b_reg);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD_A;
    else        state <= next_state;
  end

  // outputs depend only on state and registers, never on the handshake inputs
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_bit    = 1'b0;
    out_last   = 1'b0;
    case (state)
      LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid && cnt_last) next_state = LOAD_B;
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid && cnt_last) next_state = EXEC;
      end
      EXEC: begin
        next_state = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        out_bit   = result[cnt];
        out_last  = cnt_last;
        if (out_ready && cnt_last) next_state = LOAD_A;
      end
      default: next_state = LOAD_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      result <= '0;
      op_reg <= 2'b00;
    end else begin
      case (state)
        LOAD_A: begin
          if (in_xfer) begin
            a_reg[cnt] <= in_bit;
            if (cnt == '0) op_reg <= in_op;
            cnt <= cnt_last ? '0 : cnt + CW'(1);
          end
        end
        LOAD_B: begin
          if (in_xfer) begin
            b_reg[cnt] <= in_bit;
            cnt <= cnt_last ? '0 : cnt + CW'(1);
          end
        end
        EXEC: begin
          result <= op_result;
        end
        SEND: begin
          if (out_xfer) begin
            if (cnt_last) begin
              cnt   <= '0;
              a_reg <= '0;
              b_reg <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: doc/bitwise_serial_unit.md
# bitwise_serial_unit

Bit-serial front end for the 4-bit bitwise logic path. It accepts operands A and B as a serial bit stream over a valid/ready handshake and latches an operation code. It computes the bitwise result (OR, AND, XOR or NOR) and returns the result serially over a second valid/ready handshake. It sits between a narrow serial link and the ALU's bitwise datapath, driving operands into that path and collecting the result.

## Interface
- WIDTH, 4, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  in_bit/in_op valid this cycle
- in_ready  output  1  block accepts a bit this cycle
- in_bit  input  1  serial operand bit, LSB first, A then B
- in_op  input  2  opcode, sampled with first A bit: 00 OR, 01 AND, 10 XOR, 11 NOR
- out_valid  output  1  out_bit valid
- out_ready  input  1  sink accepts out_bit
- out_bit  output  1  serial result bit, LSB first
- out_last  output  1  high with result bit WIDTH-1
- busy  output  1  high in any state other than LOAD_A with zero bits received

## Operation
- Reset:
  - State = LOAD_A, bit counter = 0.
  - A, B, result and opcode registers = 0.
  - in_ready=1, out_valid=0, out_bit=0, out_last=0, busy=0.
- Input transfer: in_valid && in_ready on a rising edge. Output transfer: out_valid && out_ready on a rising edge.
- States:
  - LOAD_A:
    - in_ready=1.
    - Each transfer writes in_bit into A[cnt].
    - The first transfer (cnt=0) also latches in_op.
    - After bit WIDTH-1: cnt←0, go to LOAD_B.
  - LOAD_B:
    - in_ready=1.
    - Each transfer writes B[cnt].
    - After bit WIDTH-1: cnt←0, go to EXEC.
  - EXEC:
    - in_ready=0.
    - Lasts one cycle: result ← op(A,B) over all WIDTH bits, then go to SEND.
  - SEND:
    - in_ready=0, out_valid=1.
    - out_bit=result[cnt], out_last=(cnt==WIDTH-1).
    - Each transfer increments cnt.
    - Transfer with out_last: cnt←0, clear A/B, go to LOAD_A.
- Operation semantics: NOR = ~(A|B), masked to WIDTH bits. There is no carry and no width growth; result is exactly WIDTH bits.
- in_op is ignored on every cycle except the first A-bit transfer.
- in_bit and in_op are ignored when in_valid=0 or in_ready=0.
- Gaps in in_valid or out_ready stall the FSM indefinitely. No timeout.
- out_bit and out_last are stable while out_valid=1 and out_ready=0.
- in_ready is a registered state decode. It does not depend combinationally on in_valid.
- out_valid, out_bit and out_last are driven from registers and state only.
- Reset mid-operation (any state): all partial operands and results are discarded; outputs return to reset values asynchronously.

## Timing
- Minimum input phase: 2·WIDTH cycles with in_valid held high.
- Last B bit accepted at edge N → EXEC during cycle N+1 → out_valid=1 from edge N+2.
- With out_ready held high: WIDTH output cycles; out_last at edge N+2+WIDTH-1.
- in_ready returns to 1 the cycle after the last output transfer.
- Back-to-back operation with no stalls: one operation per 3·WIDTH+1 cycles.
- There is no overlap between output of one operation and input of the next.
- busy rises the cycle after the first A transfer and falls the cycle after the last output transfer.

## Test plan
- Reset check: assert rst_n=0 mid-cycle → in_ready=1, out_valid=0, out_bit=0, out_last=0, busy=0 immediately.
- OR, streaming:
  - Stimulus: op=00, A=0101, B=1010, in_valid and out_ready held high.
  - Required: out_valid two cycles after the last B bit; out_bit sequence 1,1,1,1; out_last on the 4th bit.
- OR with gaps:
  - Stimulus: op=00, A=1100, B=1110, in_valid toggling 1/0 every cycle.
  - Required: result 1110, serial output 0,1,1,1; total input phase 15 cycles.
- AND/XOR/NOR with opcode change:
  - Stimulus: AND on A=0101, B=0101; then XOR on A=1111, B=0101; then NOR on A=0001, B=0010. Change in_op to junk after each first A bit.
  - Required: results 0101, 1010, 1100 respectively, each using the opcode latched at its first A bit.
- Output backpressure:
  - Stimulus: OR, A=1111, B=1111; out_ready low for 5 cycles, then high.
  - Required: out_valid, out_bit=1 and out_last=0 held stable throughout the stall; 4 bits delivered after release; in_ready=0 until the last output transfer.
- Reset mid-operation:
  - Stimulus: rst_n pulsed low after 2 B bits.
  - Required: no output is produced. A fresh OR of A=0101, B=1010 then yields 1111, proving no stale bits remain.
